// File: rtl/wheel_pkg.sv
// Shared definitions for the wheel encoder emulator and the ext-sync decoder,
// so both ends agree on state encodings, phase stepping and direction.
package wheel_pkg;

    localparam int US_TICK_DIV = 100;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Phase advances by +1 (forward) or -1 mod 4 (reverse).
    localparam logic [1:0] Q_RESET    = 2'b00;
    localparam logic [1:0] Q_STEP_FWD = 2'd1;
    localparam logic [1:0] Q_STEP_REV = 2'd3;

    // Gray-coded channel pair {A, B} for a phase value.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] q);
        return {q[1] ^ q[0], q[1]};
    endfunction

endpackage

// File: rtl/quad_wheel_emulator_if.sv
// Control/status bundle between a host (master) and the wheel emulator (slave).
interface quad_wheel_emulator_if #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 32
);
    logic                i_enable;
    logic                i_start;
    logic                i_dir;
    logic [PERIOD_W-1:0] i_period;
    logic [COUNT_W-1:0]  i_step_count;
    logic                i_pos_clr;
    logic                o_ch_a;
    logic                o_ch_b;
    logic                o_busy;
    logic                o_done;
    logic [COUNT_W-1:0]  o_position;

    modport master (
        output i_enable, i_start, i_dir, i_period, i_step_count, i_pos_clr,
        input  o_ch_a, o_ch_b, o_busy, o_done, o_position
    );

    modport slave (
        input  i_enable, i_start, i_dir, i_period, i_step_count, i_pos_clr,
        output o_ch_a, o_ch_b, o_busy, o_done, o_position
    );
endinterface

// File: rtl/us_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks,
// high while the count sits at zero.
module us_tick_gen #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == W'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/quad_wheel_emulator.sv
// Quadrature A/B pulse generator emulating the track wheel encoder, with
// programmable step period, direction and count, plus emitted-position tracking.
module quad_wheel_emulator
    import wheel_pkg::*;
#(
    parameter int CLK_DIV  = US_TICK_DIV,
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    quad_wheel_emulator_if.slave  bus
);
    logic                tick;
    state_t              state;
    logic [1:0]          q;
    logic [1:0]          q_next;
    logic                ch_a;
    logic                ch_b;
    logic                step;
    logic                lat_dir;
    logic [PERIOD_W-1:0] lat_period;
    logic [PERIOD_W-1:0] per_cnt;
    logic [COUNT_W-1:0]  lat_count;
    logic [COUNT_W-1:0]  emitted;
    logic [COUNT_W-1:0]  position;

    us_tick_gen #(.DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // A step fires on the tick that closes the latched period; an abort wins over it.
    always_comb begin
        step   = (state == ST_RUN) && bus.i_enable && tick
                 && (per_cnt == lat_period - PERIOD_W'(1));
        q_next = q + ((lat_dir == DIR_REV) ? Q_STEP_REV : Q_STEP_FWD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lat_dir    <= DIR_FWD;
            lat_period <= PERIOD_W'(1);
            lat_count  <= '0;
            per_cnt    <= '0;
            emitted    <= '0;
        end else if (!bus.i_enable) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state      <= ST_RUN;
                        lat_dir    <= bus.i_dir;
                        lat_period <= (bus.i_period == '0) ? PERIOD_W'(1) : bus.i_period;
                        lat_count  <= bus.i_step_count;
                        per_cnt    <= '0;
                        emitted    <= '0;
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        per_cnt <= '0;
                        emitted <= emitted + COUNT_W'(1);
                        // A zero count means continuous; the emitted counter just wraps.
                        if (lat_count != '0 && emitted + COUNT_W'(1) == lat_count)
                            state <= ST_DONE;
                    end else if (tick) begin
                        per_cnt <= per_cnt + PERIOD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= Q_RESET;
            ch_a <= 1'b0;
            ch_b <= 1'b0;
        end else if (step) begin
            q              <= q_next;
            {ch_a, ch_b}   <= phase_to_ab(q_next);
        end
    end

    // Clear outranks a coincident step, dropping that step's contribution.
    always_ff @(posedge clk) begin
        if (!rst_n)
            position <= '0;
        else if (bus.i_pos_clr)
            position <= '0;
        else if (step)
            position <= (lat_dir == DIR_FWD) ? position + COUNT_W'(1)
                                             : position - COUNT_W'(1);
    end

    assign bus.o_ch_a     = ch_a;
    assign bus.o_ch_b     = ch_b;
    assign bus.o_busy     = (state == ST_RUN);
    assign bus.o_done     = (state == ST_DONE);
    assign bus.o_position = position;

endmodule

// File: tb/tb_quad_wheel_emulator.sv
// Scoreboard bench for quad_wheel_emulator: expected steps are queued when a run
// is started and checked (levels, position, timing) as the channels change.
module tb_quad_wheel_emulator;
    localparam int CLK_DIV  = 100;
    localparam int PERIOD_W = 16;
    localparam int COUNT_W  = 32;

    typedef struct {
        logic [1:0]  ab;
        logic [31:0] pos;
        int          offs;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cyc            = 0;
    int tb_pre         = 0;
    int start_cyc      = 0;
    int done_cnt       = 0;
    int d0             = 0;
    bit mon_en         = 1'b1;

    logic [1:0]  prev_ab = 2'b00;
    logic [1:0]  m_q     = 2'b00;
    logic [31:0] m_pos   = 32'd0;
    logic [1:0]  ab_table [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    exp_t        sb [$];

    always #5 clk = ~clk;

    quad_wheel_emulator_if #(.PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) bus ();

    quad_wheel_emulator #(
        .CLK_DIV  (CLK_DIV),
        .PERIOD_W (PERIOD_W),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter and an independent model of the microsecond prescaler phase.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n)
            tb_pre <= 0;
        else
            tb_pre <= (tb_pre == CLK_DIV - 1) ? 0 : tb_pre + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_done)
            done_cnt++;
        if (mon_en && {bus.o_ch_a, bus.o_ch_b} != prev_ab) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_step", {bus.o_ch_a, bus.o_ch_b}, prev_ab);
            end else begin
                e = sb.pop_front();
                checkOutput("step_ab", {bus.o_ch_a, bus.o_ch_b}, e.ab);
                checkOutput("step_pos", bus.o_position, e.pos);
                checkOutput("step_time", cyc - start_cyc, e.offs);
            end
        end
        prev_ab = {bus.o_ch_a, bus.o_ch_b};
    end

    task automatic applyStimulus(input logic dir, input int period, input int count,
                                 input int n_push, input int clr_step);
        int eff;
        exp_t e;
        eff = (period == 0) ? 1 : period;
        for (int k = 1; k <= n_push; k++) begin
            m_q = dir ? m_q + 2'd1 : m_q - 2'd1;
            if (k == clr_step)
                m_pos = 32'd0;
            else
                m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
            e.ab   = ab_table[m_q];
            e.pos  = m_pos;
            e.offs = k * eff * CLK_DIV;
            sb.push_back(e);
        end
        bus.i_dir        = dir;
        bus.i_period     = period[PERIOD_W-1:0];
        bus.i_step_count = count;
        bus.i_enable     = 1'b1;
        @(negedge clk);
        while (tb_pre != 0)
            @(negedge clk);
        bus.i_start = 1'b1;
        start_cyc   = cyc + 1;
        @(negedge clk);
        bus.i_start = 1'b0;
        checkOutput("busy_after_start", bus.o_busy, 1);
    endtask

    task automatic waitQueue(input int max_cyc, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic waitIdle(input int max_cyc, input string tag);
        int n = 0;
        while ((bus.o_busy || bus.o_done) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, bus.o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_enable     = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_dir        = 1'b0;
        bus.i_period     = '0;
        bus.i_step_count = '0;
        bus.i_pos_clr    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_a", bus.o_ch_a, 0);
        checkOutput("rst_b", bus.o_ch_b, 0);
        checkOutput("rst_busy", bus.o_busy, 0);
        checkOutput("rst_done", bus.o_done, 0);
        checkOutput("rst_pos", bus.o_position, 0);
        rst_n = 1'b1;

        $display("[TB] forward run, period 2, count 4");
        d0 = done_cnt;
        applyStimulus(1'b1, 2, 4, 4, 0);
        waitQueue(1000, "t1_drain");
        waitIdle(10, "t1_idle");
        checkOutput("t1_done_pulses", done_cnt - d0, 1);
        checkOutput("t1_pos", bus.o_position, 32'd4);

        $display("[TB] reverse run, period 1, count 3");
        d0 = done_cnt;
        applyStimulus(1'b0, 1, 3, 3, 0);
        waitQueue(500, "t2_drain");
        waitIdle(10, "t2_idle");
        checkOutput("t2_done_pulses", done_cnt - d0, 1);
        checkOutput("t2_pos", bus.o_position, 32'd1);

        $display("[TB] period 0 treated as 1, count 2");
        d0 = done_cnt;
        applyStimulus(1'b1, 0, 2, 2, 0);
        waitQueue(400, "t3_drain");
        waitIdle(10, "t3_idle");
        checkOutput("t3_done_pulses", done_cnt - d0, 1);
        checkOutput("t3_pos", bus.o_position, 32'd3);

        $display("[TB] continuous run then abort");
        @(negedge clk);
        bus.i_pos_clr = 1'b1;
        @(negedge clk);
        bus.i_pos_clr = 1'b0;
        checkOutput("t4_pos_clr_idle", bus.o_position, 0);
        m_pos = 32'd0;
        d0 = done_cnt;
        applyStimulus(1'b1, 1, 0, 10, 0);
        waitQueue(1200, "t4_drain");
        bus.i_enable = 1'b0;
        @(negedge clk);
        checkOutput("t4_busy_abort", bus.o_busy, 0);
        repeat (300) @(negedge clk);
        checkOutput("t4_ab_hold", {bus.o_ch_a, bus.o_ch_b}, ab_table[m_q]);
        checkOutput("t4_pos", bus.o_position, 32'd10);
        checkOutput("t4_no_done", done_cnt - d0, 0);

        $display("[TB] position clear on a step, mid-run start and period change");
        d0 = done_cnt;
        applyStimulus(1'b1, 1, 4, 4, 2);
        while (cyc < start_cyc + 150)
            @(negedge clk);
        bus.i_period     = 16'd7;
        bus.i_dir        = 1'b0;
        bus.i_step_count = 32'd1;
        bus.i_start      = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        while (cyc < start_cyc + 199)
            @(negedge clk);
        bus.i_pos_clr = 1'b1;
        @(negedge clk);
        bus.i_pos_clr = 1'b0;
        checkOutput("t5_pos_clr_step", bus.o_position, 0);
        waitQueue(600, "t5_drain");
        waitIdle(10, "t5_idle");
        checkOutput("t5_done_pulses", done_cnt - d0, 1);
        checkOutput("t5_pos", bus.o_position, 32'd2);

        $display("[TB] reset during a run");
        applyStimulus(1'b1, 1, 0, 3, 0);
        waitQueue(500, "t6_drain");
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_a", bus.o_ch_a, 0);
        checkOutput("t6_rst_b", bus.o_ch_b, 0);
        checkOutput("t6_rst_pos", bus.o_position, 0);
        checkOutput("t6_rst_busy", bus.o_busy, 0);
        rst_n = 1'b1;
        m_q   = 2'b00;
        m_pos = 32'd0;
        sb.delete();
        @(negedge clk);
        mon_en = 1'b1;
        applyStimulus(1'b1, 1, 2, 2, 0);
        waitQueue(400, "t6_drain2");
        waitIdle(10, "t6_idle");
        checkOutput("t6_pos", bus.o_position, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
